// File: rtl/raw10g_pkg.sv
// Shared types and constants for the 10GBASE-R raw block datapath.
package raw10g_pkg;

    localparam int unsigned DATA_W = 66;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef logic [65:0] blk_t;

    // Fill level of the 3-entry read-side buffer.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2,
        OccFull  = 2'd3
    } occ_e;

    // Only the data and control sync headers are legal on the link.
    function automatic logic sh_legal(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// 3-entry register buffer absorbing the one-cycle FIFO read latency.
// Entry 0 is the head; a pop shifts the queue forward and a push lands
// behind whatever remains after that pop.
module fifo_rd_skid_buf
    import raw10g_pkg::*;
#(
    parameter int unsigned DATA_W = raw10g_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ,
    output logic              valid
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] mem_q [3];
    logic [DATA_W-1:0] mem_d [3];
    logic [1:0]        wr_idx;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OccEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state: +1 on push, -1 on pop, unchanged on both.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OccEmpty: if (push)         state_d = OccOne;
            OccOne:   if (push && !pop) state_d = OccTwo;
                      else if (!push && pop) state_d = OccEmpty;
            OccTwo:   if (push && !pop) state_d = OccFull;
                      else if (!push && pop) state_d = OccOne;
            // Push while full is excluded by the upstream credit rule.
            OccFull:  if (!push && pop) state_d = OccTwo;
            default:  state_d = OccEmpty;
        endcase
    end

    // Occupancy-derived outputs.
    always_comb begin
        occ   = 2'(state_q);
        valid = (state_q != OccEmpty);
    end

    // Entry next state: shift on pop, then write the tail slot.
    always_comb begin
        mem_d  = mem_q;
        wr_idx = occ - {1'b0, pop};
        if (pop) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[2];
        end
        if (push && (wr_idx != 2'd3)) begin
            mem_d[wr_idx] = push_data;
        end
    end

    // Entry storage; cleared so the head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign head = mem_q[0];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the 66-bit link FIFO. Pops the FIFO on a
// credit basis (buffer fill plus the read in flight never exceeds 3) and
// presents blocks on a valid/ready stream at full rate. fifo_rd_en
// depends only on registered state, the empty flag and reset, never on
// m_ready. Optional sync header check: FIFO_RD_SYNC_HDR_CHECK_EN.
module fifo_rd_stream
    import raw10g_pkg::*;
#(
    parameter int unsigned DATA_W = raw10g_pkg::DATA_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    output logic              fifo_rd_en,
    input  logic              fifo_rd_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  blk_cnt
`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
   ,output logic              hdr_err,
    output logic [15:0]       hdr_err_cnt
`endif
);

    logic             infl_q;
    logic [1:0]       occ;
    logic             pop;
    logic [CNT_W-1:0] blk_cnt_q;

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (infl_q),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .head      (m_data),
        .occ       (occ),
        .valid     (m_valid)
    );

    // Credit-based pop request; reserves a slot for the read in flight.
    always_comb begin
        fifo_rd_en = !rd_rst && !fifo_rd_empty && (({1'b0, occ} + {2'b00, infl_q}) < 3'd3);
        pop        = m_valid && m_ready;
    end

    // In-flight read tracker and wrapping transfer counter.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            infl_q    <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            infl_q <= fifo_rd_en;
            if (pop) begin
                blk_cnt_q <= blk_cnt_q + CNT_W'(1);
            end
        end
    end

    assign blk_cnt = blk_cnt_q;

`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
    logic [15:0] hdr_err_cnt_q;

    // Flag an illegal header on the word captured this cycle.
    always_comb begin
        hdr_err = infl_q && !rd_rst && !sh_legal(fifo_rd_data[DATA_W-1 -: 2]);
    end

    // Saturating illegal-header counter.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            hdr_err_cnt_q <= '0;
        end else if (hdr_err && (hdr_err_cnt_q != 16'hFFFF)) begin
            hdr_err_cnt_q <= hdr_err_cnt_q + 16'd1;
        end
    end

    assign hdr_err_cnt = hdr_err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the
// DUT, every block handed to the FIFO is also queued as expected output,
// and a negedge monitor pops and compares on each stream transfer.
module tb_fifo_rd_stream;
    import raw10g_pkg::*;

    localparam int unsigned DW = 66;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rd_rst;
    logic          fifo_rd_en, fifo_rd_en4;
    logic          fifo_rd_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          m_valid, m_valid4;
    logic          m_ready;
    logic [DW-1:0] m_data, m_data4;
    logic [31:0]   blk_cnt;
    logic [3:0]    blk_cnt4;
`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
    logic          hdr_err, hdr_err4;
    logic [15:0]   hdr_err_cnt, hdr_err_cnt4;
`endif

    fifo_rd_stream #(.DATA_W(DW), .CNT_W(32)) dut (
        .rd_clk        (clk),
        .rd_rst        (rd_rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .blk_cnt       (blk_cnt)
`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
       ,.hdr_err       (hdr_err),
        .hdr_err_cnt   (hdr_err_cnt)
`endif
    );

    // Narrow-counter instance on identical stimulus, for the wrap check.
    fifo_rd_stream #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .rd_clk        (clk),
        .rd_rst        (rd_rst),
        .fifo_rd_en    (fifo_rd_en4),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .m_valid       (m_valid4),
        .m_ready       (m_ready),
        .m_data        (m_data4),
        .blk_cnt       (blk_cnt4)
`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
       ,.hdr_err       (hdr_err4),
        .hdr_err_cnt   (hdr_err_cnt4)
`endif
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string nm, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // FIFO model and scoreboard.
    blk_t          fq[$];
    blk_t          exp_q[$];
    logic [DW-1:0] pend;
    bit            pend_v = 0;
    bit            push_v = 0;
    logic [DW-1:0] push_blk;
    int            ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit            rst_req = 1;

    function automatic blk_t rand_blk();
        logic [1:0] sh;
        sh = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        return {sh, $urandom, $urandom};
    endfunction

    function automatic void push_fifo(input blk_t b);
        fq.push_back(b);
        exp_q.push_back(b);
    endfunction

    // One clock: drive inputs after the edge, sample pop request at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        rd_rst   = rst_req;
        push_v   = pend_v;
        push_blk = pend;
        fifo_rd_data = pend_v ? pend : {2'($urandom), $urandom, $urandom};
        pend_v   = 0;
        fifo_rd_empty = (fq.size() == 0);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        @(negedge clk);
        if (fifo_rd_en && !rd_rst && (fq.size() > 0)) begin
            pend   = fq.pop_front();
            pend_v = 1;
        end
    endtask

    // Monitor state.
    int   cyc = 0;
    int   held = 0;        // words requested from the FIFO but not yet transferred
    int   xfers = 0;
    int   first_en = -1, first_valid = -1, first_xfer = -1, last_xfer = -1;
    bit   prev_stall = 0;
    logic [DW-1:0] prev_data;
`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
    int   hdr_pulses = 0;
    int   exp_hcnt = 0;
`endif

    always @(negedge clk) begin
        blk_t e;
        cyc++;
        if (rd_rst) begin
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_blk_cnt", blk_cnt, 0);
            prev_stall = 0;
        end else begin
            if (fifo_rd_empty) chk("pop_while_empty", fifo_rd_en, 0);
            chk("credit_limit", (held <= 3), 1);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
            if (fifo_rd_en && first_en < 0) first_en = cyc;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_block", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", m_data, e);
                end
                chk("blk_cnt", blk_cnt, xfers[31:0]);
                chk("blk_cnt4", blk_cnt4, xfers[3:0]);
                xfers++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
            begin
                bit bad;
                bad = push_v && ((push_blk[65:64] == 2'b00) || (push_blk[65:64] == 2'b11));
                chk("hdr_err", hdr_err, bad);
                chk("hdr_err_cnt", hdr_err_cnt, exp_hcnt[15:0]);
                if (hdr_err) hdr_pulses++;
                if (bad && exp_hcnt < 65535) exp_hcnt++;
            end
`endif
            held = held + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Run until every queued block has been delivered, bounded.
    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            #1;
            if (exp_q.size() == 0 && fq.size() == 0 && !pend_v && !m_valid && held == 0)
                return;
        end
        chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int base;
        int total;
        rd_rst        = 1'b1;
        m_ready       = 1'b0;
        fifo_rd_empty = 1'b1;
        fifo_rd_data  = '0;
        push_blk      = '0;
        pend          = '0;

        // Reset with a non-empty FIFO.
        for (int i = 0; i < 4; i++) push_fifo(rand_blk());
        repeat (3) step();
        rst_req = 0;

        // Latency and full-rate streaming of 512 blocks.
        for (int i = 0; i < 508; i++) push_fifo(rand_blk());
        drain(2000);
        chk("first_word_latency", 32'(first_valid - first_en), 2);
        chk("full_rate_span", 32'(last_xfer - first_xfer), 511);
        chk("stream_count", 32'(xfers), 512);
        chk("blk_cnt_512", blk_cnt, 512);
        chk("blk_cnt4_wrap_512", blk_cnt4, 0);

        // Backpressure mid-stream.
        base = xfers;
        for (int i = 0; i < 20; i++) push_fifo(rand_blk());
        ready_mode = 0;
        repeat (6) step();
        ready_mode = 2;
        repeat (10) step();
        chk("stall_rd_en", fifo_rd_en, 0);
        chk("stall_m_valid", m_valid, 1);
        ready_mode = 0;
        step();
        chk("resume_same_cycle", fifo_rd_en, 0);
        step();
        chk("resume_next_cycle", fifo_rd_en, 1);
        drain(500);
        chk("bp_count", 32'(xfers - base), 20);

        // Empty boundary with random readiness.
        base  = xfers;
        total = 0;
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) push_fifo(rand_blk());
            total += n;
            repeat ($urandom_range(1, 6)) step();
        end
        drain(1000);
        chk("boundary_valid_low", m_valid, 0);
        chk("boundary_count", 32'(xfers - base), 32'(total));

        // Counter wrap on the narrow instance: 17 more blocks.
        base = xfers;
        ready_mode = 0;
        for (int i = 0; i < 17; i++) push_fifo(rand_blk());
        drain(200);
        chk("wrap_blk_cnt4", blk_cnt4, 4'((base + 17) % 16));
        chk("wrap_blk_cnt", blk_cnt, 32'(base + 17));

`ifdef FIFO_RD_SYNC_HDR_CHECK_EN
        begin
            logic [1:0] hs [4];
            int hbase;
            hs[0] = 2'b01; hs[1] = 2'b11; hs[2] = 2'b10; hs[3] = 2'b00;
            hbase = hdr_pulses;
            base  = xfers;
            for (int i = 0; i < 4; i++) push_fifo({hs[i], $urandom, $urandom});
            drain(100);
            chk("hdr_pulses", 32'(hdr_pulses - hbase), 2);
            chk("hdr_cnt_2", hdr_err_cnt, 2);
            chk("hdr_forwarded", 32'(xfers - base), 4);
            for (int i = 0; i < 70000; i++)
                push_fifo({((i % 2) != 0) ? 2'b11 : 2'b00, $urandom, $urandom});
            drain(75000);
            chk("hdr_cnt_sat", hdr_err_cnt, 16'hFFFF);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage placed directly downstream of the 66-bit link FIFO's read port. It watches `fifo_rd_empty` and issues `fifo_rd_en` to pop the FIFO. The FIFO's data arrives one cycle after each pop (no output register), and this block absorbs that latency in a 3-entry buffer. It presents the blocks on a valid/ready stream at full throughput, with no combinational path from `m_ready` to `fifo_rd_en`.

## Interface
Parameters:
- `DATA_W`, default 66: block width (2-bit sync header plus 64-bit payload).
- `CNT_W`, default 32: width of the transferred-block counter.

Ports:
- `rd_clk`  in  1: single clock, the same clock as the FIFO read side.
- `rd_rst`  in  1: reset, synchronous and active-high.
- `fifo_rd_en`  out  1: FIFO pop request.
- `fifo_rd_empty`  in  1: FIFO empty flag.
- `fifo_rd_data`  in  DATA_W: FIFO read data, valid one cycle after `fifo_rd_en`.
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready.
- `m_data`  out  DATA_W: stream data; bits [65:64] carry the sync header.
- `blk_cnt`  out  CNT_W: count of accepted stream transfers; wraps.
- `hdr_err`  out  1: one-cycle pulse for an invalid sync header (present only under the macro).
- `hdr_err_cnt`  out  16: saturating count of invalid headers (present only under the macro).

## Operation
State and occupancy:
- `occ` (0..3) holds the buffer fill. Its states are EMPTY, ONE, TWO and FULL.
- `infl` is a register equal to the previous cycle's `fifo_rd_en`.

Pop and capture:
- `fifo_rd_en = !fifo_rd_empty && (occ + infl < 3)`. It is combinational from registered state and the empty flag only.
- When `infl`=1, `fifo_rd_data` is written into the buffer tail in that cycle.

Stream output:
- `m_valid = (occ != 0)`.
- `m_data` is the buffer head. The head register holds its value while `m_valid && !m_ready`.
- A pop occurs when `m_valid && m_ready`.

Transitions:
- `occ` next = `occ` + push − pop.
- Simultaneous push and pop leaves `occ` unchanged, and the pushed entry lands behind the remaining entries.
- Push with `occ`=3 cannot occur, because the credit rule prevents it. The bench asserts this.

Ordering and counting:
- Blocks leave in FIFO order: no reordering, no drops, no duplication.
- `blk_cnt` increments on every pop and wraps from 2^CNT_W−1 to 0.

Reset (`rd_rst`, sampled at the clock edge):
- The following are cleared: `occ`, `infl`, `m_valid`, `m_data` (to 0), `blk_cnt`, `hdr_err`, `hdr_err_cnt`.
- `fifo_rd_en` is 0 while `rd_rst`=1.
- A read in flight when reset is asserted is discarded. The FIFO shares `rd_rst`, so no stale data survives.

## Timing
- First-word latency: if `fifo_rd_empty` falls before edge t, `fifo_rd_en`=1 in cycle t, data is captured at the end of t+1, and `m_valid`=1 in cycle t+2.
- Steady state with `m_ready` held at 1: one block per cycle, with `occ` oscillating 1↔1 and `infl`=1.
- After `m_ready` falls with the FIFO non-empty: `occ` reaches 3 within 2 cycles and `fifo_rd_en` drops.
- After `m_ready` returns: the pop of that cycle frees a credit and `fifo_rd_en` resumes in the next cycle.
- `fifo_rd_empty` asserted while `infl`=1: the in-flight word is still captured. The flag gates only new pops.

## Configuration
Macro `FIFO_RD_SYNC_HDR_CHECK_EN`.

When defined:
- The header of each pushed word is checked; 2'b01 (data) and 2'b10 (control) are legal.
- An illegal header (2'b00 or 2'b11) pulses `hdr_err` for one cycle in the push cycle.
- `hdr_err_cnt` increments and saturates at 16'hFFFF.
- The block is forwarded unchanged; the check never stalls the stream.

When not defined, `hdr_err` and `hdr_err_cnt` ports and logic are absent.

## Structure
Package `raw10g_pkg` holds:
- `DATA_W` = 66.
- `SH_DATA` = 2'b01.
- `SH_CTRL` = 2'b10.
- Typedef `blk_t` (logic [65:0]).

Sub-module `fifo_rd_skid_buf`:
- 3-entry register buffer with push/pop/occ.
- Head drives `m_data`.

The credit logic, counters and header check live in the top.

## Test plan
- **Reset:** drive `rd_rst`=1 for 3 cycles with the FIFO non-empty -> `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `blk_cnt`=0 throughout.
- **Latency and streaming:** FIFO holds 512 blocks, `m_ready`=1 -> first `m_valid` 2 cycles after the first `fifo_rd_en`; 512 consecutive transfers in FIFO order; `blk_cnt`=512.
- **Backpressure:** stream 20 blocks, drop `m_ready` for 10 cycles mid-stream -> `occ`=3, `fifo_rd_en`=0 during the stall, `m_data` stable, no loss or duplication; output sequence equals the input.
- **Empty boundary:** FIFO empties with one read in flight; `m_ready` random 50% -> the final block is delivered, `m_valid` falls after it, no spurious pop while `fifo_rd_empty`=1.
- **Wrap:** `CNT_W`=4, transfer 17 blocks -> `blk_cnt`=1.
- **Header check (`FIFO_RD_SYNC_HDR_CHECK_EN` defined):**
  - Inject headers 01, 11, 10, 00 -> two `hdr_err` pulses and `hdr_err_cnt`=2; all 4 blocks forwarded.
  - Force 70000 bad headers -> `hdr_err_cnt` holds at 16'hFFFF.
